// File: rtl/floor_persp_raster.sv
// floor_persp_raster: mode-7 perspective floor rasteriser with map/palette texel lookup
module xilinx_single_port_ram_read_first #(
  parameter int    RAM_WIDTH       = 18,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter string INIT_FILE       = ""
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);
  logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;
  // read-first array access
  always_ff @(posedge clka)
    if (ena) begin
      if (wea) ram[addra] <= dina;
      ram_data <= ram[addra];
    end
  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low
    assign douta = ram_data;
  end else begin : g_high
    // optional output register for the two-cycle read
    always_ff @(posedge clka)
      if (rsta) douta <= '0;
      else if (regcea) douta <= ram_data;
  end
endmodule

module floor_persp_raster #(
  parameter int          H_ACTIVE     = 1280,
  parameter int          V_ACTIVE     = 720,
  parameter int          HORIZON      = 360,
  parameter int          FRAC         = 8,
  parameter int          TEXEL_SHIFT  = 3,
  parameter int          MAP_W        = 160,
  parameter int          MAP_H        = 90,
  parameter int          MAP_X0       = 720,
  parameter int          MAP_Y0       = 720,
  parameter int          PIX_BITS     = 4,
  parameter int          WRAP         = 0,
  parameter logic [23:0] SKY_COLOR    = 24'h87CEFA,
  parameter logic [23:0] GROUND_COLOR = 24'h013220,
  parameter string       MAP_FILE     = "map.mem",
  parameter string       PALETTE_FILE = "palette.mem"
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic signed [15:0] farl_x,
  input  logic signed [15:0] farl_y,
  input  logic signed [15:0] farr_x,
  input  logic signed [15:0] farr_y,
  input  logic signed [15:0] nearl_x,
  input  logic signed [15:0] nearl_y,
  input  logic signed [15:0] nearr_x,
  input  logic signed [15:0] nearr_y,
  output logic [7:0]         red_out,
  output logic [7:0]         green_out,
  output logic [7:0]         blue_out,
  output logic [10:0]        hcount_out,
  output logic [9:0]         vcount_out,
  output logic               frame_sync_out
);
  localparam int RECIP_V = (65536 + (V_ACTIVE - HORIZON - 1) / 2) / (V_ACTIVE - HORIZON - 1);
  localparam int RECIP_H = (65536 + (H_ACTIVE - 1) / 2) / (H_ACTIVE - 1);
  localparam int SH = FRAC + TEXEL_SHIFT;
  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);
  localparam int AW = $clog2(MAP_W * MAP_H);
  typedef struct packed {
    logic        act;
    logic        sky;
    logic        on;
    logic [10:0] h;
    logic [9:0]  v;
  } tag_t;
  logic signed [15:0] crn [8];
  logic primed, latch, row_go, on_raw;
  logic signed [31:0] el_x, el_y, er_x, er_y, dvl_x, dvl_y, dvr_x, dvr_y;
  logic signed [31:0] dh_x, dh_y, p_x, p_y, tx_raw, ty_raw;
  logic [XW-1:0] tx1;
  logic [YW-1:0] ty1;
  logic [AW-1:0] addr;
  logic [PIX_BITS-1:0] pix;
  logic [23:0] rgb, col;
  tag_t tag [6];
  function automatic logic signed [31:0] scale(input logic signed [31:0] a, input logic signed [31:0] r);
    logic signed [47:0] p;
    p = 48'(a) * 48'(r);
    return 32'(p >>> 16);
  endfunction
  function automatic logic signed [31:0] wx(input logic signed [15:0] c);
    return 32'(c) <<< FRAC;
  endfunction
  assign latch = hcount_in == 11'd0 && vcount_in == 10'(V_ACTIVE);
  assign row_go = vcount_in >= 10'(HORIZON - 1) && vcount_in <= 10'(V_ACTIVE - 2);
  assign tx_raw = (p_x >>> SH) - (MAP_X0 >>> TEXEL_SHIFT);
  assign ty_raw = (p_y >>> SH) - (MAP_Y0 >>> TEXEL_SHIFT);
  assign on_raw = WRAP != 0 || (tx_raw >= 0 && tx_raw < MAP_W && ty_raw >= 0 && ty_raw < MAP_H);
  assign {red_out, green_out, blue_out} = col;
  // shadow the frustum once per frame; rendering stays dark until the first latch
  always_ff @(posedge pixel_clk_in or posedge rst_in)
    if (rst_in) begin
      crn <= '{default: '0};
      frame_sync_out <= 1'b0;
      primed <= 1'b0;
    end else begin
      frame_sync_out <= latch;
      if (latch) begin
        crn <= '{farl_x, farl_y, farr_x, farr_y, nearl_x, nearl_y, nearr_x, nearr_y};
        primed <= 1'b1;
      end
    end
  // incremental frustum walk: frame setup, per-line steps, per-pixel add
  always_ff @(posedge pixel_clk_in or posedge rst_in)
    if (rst_in) begin
      {el_x, el_y, er_x, er_y, dvl_x, dvl_y, dvr_x, dvr_y} <= '0;
      {dh_x, dh_y, p_x, p_y} <= '0;
    end else if (frame_sync_out) begin
      dvl_x <= scale(wx(crn[4]) - wx(crn[0]), RECIP_V);
      dvl_y <= scale(wx(crn[5]) - wx(crn[1]), RECIP_V);
      dvr_x <= scale(wx(crn[6]) - wx(crn[2]), RECIP_V);
      dvr_y <= scale(wx(crn[7]) - wx(crn[3]), RECIP_V);
      el_x <= wx(crn[0]);
      el_y <= wx(crn[1]);
      er_x <= wx(crn[2]);
      er_y <= wx(crn[3]);
    end else if (row_go && hcount_in == 11'(H_ACTIVE + 2)) begin
      dh_x <= scale(er_x - el_x, RECIP_H);
      dh_y <= scale(er_y - el_y, RECIP_H);
    end else if (row_go && hcount_in == 11'(H_ACTIVE + 3)) begin
      p_x <= el_x;
      p_y <= el_y;
      el_x <= el_x + dvl_x;
      el_y <= el_y + dvl_y;
      er_x <= er_x + dvr_x;
      er_y <= er_y + dvr_y;
    end else if (hcount_in < 11'(H_ACTIVE)) begin
      p_x <= p_x + dh_x;
      p_y <= p_y + dh_y;
    end
  // texel and address stages plus the flag/count pipeline feeding the output mux
  always_ff @(posedge pixel_clk_in or posedge rst_in)
    if (rst_in) begin
      tx1 <= '0;
      ty1 <= '0;
      addr <= '0;
      tag <= '{default: '0};
    end else begin
      tx1 <= on_raw ? tx_raw[XW-1:0] : '0;
      ty1 <= on_raw ? ty_raw[YW-1:0] : '0;
      addr <= AW'(ty1 * MAP_W + tx1);
      tag[0] <= '{act: primed && hcount_in < 11'(H_ACTIVE) && vcount_in < 10'(V_ACTIVE),
                  sky: vcount_in < 10'(HORIZON), on: on_raw, h: hcount_in, v: vcount_in};
      for (int i = 1; i < 6; i++) tag[i] <= tag[i-1];
    end
  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH(PIX_BITS), .RAM_DEPTH(MAP_W * MAP_H),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .INIT_FILE(MAP_FILE)
  ) u_map (
    .addra(addr), .dina('0), .clka(pixel_clk_in), .wea(1'b0), .ena(1'b1),
    .rsta(rst_in), .regcea(1'b1), .douta(pix)
  );
  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH(24), .RAM_DEPTH(1 << PIX_BITS),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .INIT_FILE(PALETTE_FILE)
  ) u_pal (
    .addra(pix), .dina('0), .clka(pixel_clk_in), .wea(1'b0), .ena(1'b1),
    .rsta(rst_in), .regcea(1'b1), .douta(rgb)
  );
  // final colour select with matched-latency counts
  always_ff @(posedge pixel_clk_in or posedge rst_in)
    if (rst_in) begin
      col <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      col <= !tag[5].act ? 24'h0 : tag[5].sky ? SKY_COLOR : !tag[5].on ? GROUND_COLOR : rgb;
      hcount_out <= tag[5].h;
      vcount_out <= tag[5].v;
    end
endmodule

// File: tb/tb_floor_persp_raster.sv
// tb_floor_persp_raster: directed vectors for the perspective floor rasteriser
module tb_floor_persp_raster;
  localparam logic [23:0] SKY = 24'h87CEFA;
  localparam logic [23:0] GND = 24'h013220;
  typedef struct {
    int          h;
    int          v;
    logic [23:0] e;
    logic [23:0] ew;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [10:0] h = '0;
  logic [9:0] v = '0;
  logic signed [15:0] flx, fly, frx, fry, nlx, nly, nrx, nry;
  logic [7:0] r, g, b, rw, gw, bw;
  logic [10:0] ho, how;
  logic [9:0] vo, vow;
  logic fs, fsw;
  logic [23:0] cap_rgb [1280];
  logic [23:0] cap_w [1280];
  logic [10:0] cap_h [1280];
  logic [9:0] cap_v [1280];
  vec_t tv [8];
  int checks = 0, errors = 0;
  floor_persp_raster dut (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_in(h), .vcount_in(v),
    .farl_x(flx), .farl_y(fly), .farr_x(frx), .farr_y(fry),
    .nearl_x(nlx), .nearl_y(nly), .nearr_x(nrx), .nearr_y(nry),
    .red_out(r), .green_out(g), .blue_out(b),
    .hcount_out(ho), .vcount_out(vo), .frame_sync_out(fs)
  );
  floor_persp_raster #(.WRAP(1), .MAP_W(128), .MAP_H(64)) dut_w (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_in(h), .vcount_in(v),
    .farl_x(flx), .farl_y(fly), .farr_x(frx), .farr_y(fry),
    .nearl_x(nlx), .nearl_y(nly), .nearr_x(nrx), .nearr_y(nry),
    .red_out(rw), .green_out(gw), .blue_out(bw),
    .hcount_out(how), .vcount_out(vow), .frame_sync_out(fsw)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] mval(int a);
    return 4'((a * 7) ^ (a >> 3));
  endfunction
  function automatic logic [23:0] pval(int i);
    return {8'(i * 16 + 3), 8'(200 - i * 9), 8'(i * 11 + 40)};
  endfunction
  function automatic logic [23:0] tex(int a);
    return pval(int'(mval(a)));
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int hh, input int vv);
    h = 11'(hh);
    v = 10'(vv);
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int vv, input int h0, input int h1);
    int n;
    n = h1 - h0 + 1;
    for (int j = 0; j < n + 6; j++) begin
      cyc(j < n ? h0 + j : 1290, vv);
      if (j >= 6) begin
        cap_rgb[j-6] = {r, g, b};
        cap_w[j-6] = {rw, gw, bw};
        cap_h[j-6] = ho;
        cap_v[j-6] = vo;
      end
    end
  endtask
  task automatic rows(input int a, input int z);
    for (int vv = a; vv <= z; vv++) begin
      cyc(1282, vv);
      cyc(1283, vv);
    end
  endtask
  task automatic corners(input int fx0, input int fy0, input int fx1, input int fy1,
                         input int nx0, input int ny0, input int nx1, input int ny1);
    flx = 16'(fx0); fly = 16'(fy0); frx = 16'(fx1); fry = 16'(fy1);
    nlx = 16'(nx0); nly = 16'(ny0); nrx = 16'(nx1); nry = 16'(ny1);
  endtask
  task automatic do_latch();
    cyc(0, 720);
    chk("frame_sync_high", 32'(fs), 1);
    chk("frame_sync_high_w", 32'(fsw), 1);
    cyc(1, 720);
    chk("frame_sync_low", 32'(fs), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
  initial begin
    for (int a = 0; a < 160 * 90; a++) dut.u_map.ram[a] = mval(a);
    for (int a = 0; a < 128 * 64; a++) dut_w.u_map.ram[a] = mval(a);
    for (int i = 0; i < 16; i++) begin
      dut.u_pal.ram[i] = pval(i);
      dut_w.u_pal.ram[i] = pval(i);
    end
    tv[0] = '{5, 100, SKY, SKY};
    tv[1] = '{1279, 359, SKY, SKY};
    tv[2] = '{0, 360, tex(5635), tex(4515)};
    tv[3] = '{640, 500, tex(5635), tex(4515)};
    tv[4] = '{1279, 719, tex(5635), tex(4515)};
    tv[5] = '{1281, 500, 24'h0, 24'h0};
    tv[6] = '{100, 725, 24'h0, 24'h0};
    tv[7] = '{0, 0, SKY, SKY};
    corners(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000);
    h = 11'd500;
    v = 10'd400;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", 32'({r, g, b}), 0);
    chk("reset_hcount", 32'(ho), 0);
    chk("reset_vcount", 32'(vo), 0);
    chk("reset_frame_sync", 32'(fs), 0);
    rst = 1'b0;
    run(100, 5, 5);
    chk("prelatch_black", 32'(cap_rgb[0]), 0);
    // uniform view: every ground pixel samples texel (35,35)
    do_latch();
    rows(359, 359);
    for (int k = 0; k < 8; k++) begin
      run(tv[k].v, tv[k].h, tv[k].h);
      chk($sformatf("vec%0d_rgb", k), 32'(cap_rgb[0]), 32'(tv[k].e));
      chk($sformatf("vec%0d_rgb_wrap", k), 32'(cap_w[0]), 32'(tv[k].ew));
      chk($sformatf("vec%0d_hcount", k), 32'(cap_h[0]), 32'(tv[k].h));
      chk($sformatf("vec%0d_vcount", k), 32'(cap_v[0]), 32'(tv[k].v));
    end
    // vertical step: near edge one world unit further per line
    corners(1000, 1000, 1000, 1000, 1000, 1359, 1000, 1359);
    do_latch();
    for (int vv = 359; vv <= 718; vv++) begin
      if (vv == 360) begin
        run(360, 0, 0);
        chk("vstep_360", 32'(cap_rgb[0]), 32'(tex(5635)));
        chk("vstep_360_w", 32'(cap_w[0]), 32'(tex(4515)));
      end
      if (vv == 376) begin
        run(376, 0, 0);
        chk("vstep_376", 32'(cap_rgb[0]), 32'(tex(5955)));
        chk("vstep_376_w", 32'(cap_w[0]), 32'(tex(4771)));
      end
      rows(vv, vv);
    end
    run(719, 0, 0);
    chk("vstep_719", 32'(cap_rgb[0]), 32'(tex(12675)));
    chk("vstep_719_w", 32'(cap_w[0]), 32'(tex(1955)));
    // horizontal ramp across the map width on the first ground line
    corners(720, 800, 2000, 800, 720, 800, 2000, 800);
    do_latch();
    rows(359, 359);
    run(360, 0, 1279);
    chk("ramp_h0", 32'(cap_rgb[0]), 32'(tex(1600)));
    chk("ramp_h640", 32'(cap_rgb[640]), 32'(tex(1679)));
    chk("ramp_h1279", 32'(cap_rgb[1279]), 32'(tex(1759)));
    chk("ramp_h0_w", 32'(cap_w[0]), 32'(tex(1280)));
    chk("ramp_h640_w", 32'(cap_w[640]), 32'(tex(1359)));
    chk("ramp_h1279_w", 32'(cap_w[1279]), 32'(tex(1311)));
    chk("ramp_hcount640", 32'(cap_h[640]), 640);
    // corner change mid-frame is deferred to the next latch, then off-map view
    corners(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000);
    do_latch();
    rows(359, 399);
    corners(100, 100, 100, 100, 100, 100, 100, 100);
    run(400, 10, 10);
    chk("midframe_hold", 32'(cap_rgb[0]), 32'(tex(5635)));
    chk("midframe_hold_w", 32'(cap_w[0]), 32'(tex(4515)));
    do_latch();
    rows(359, 359);
    run(360, 10, 10);
    chk("offmap_clamp", 32'(cap_rgb[0]), 32'(GND));
    chk("offmap_wrap", 32'(cap_w[0]), 32'(tex(6450)));
    // asynchronous reset while sky pixels are streaming
    for (int i = 0; i < 10; i++) cyc(i, 100);
    chk("pre_reset_sky", 32'({r, g, b}), 32'(SKY));
    h = 11'd500;
    v = 10'd400;
    rst = 1'b1;
    #1;
    chk("async_reset_rgb", 32'({r, g, b}), 0);
    chk("async_reset_rgb_w", 32'({rw, gw, bw}), 0);
    chk("async_reset_hcount", 32'(ho), 0);
    chk("async_reset_vcount", 32'(vo), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(100, 5, 5);
    chk("post_reset_black", 32'(cap_rgb[0]), 0);
    do_latch();
    run(100, 5, 5);
    chk("post_reset_sky", 32'(cap_rgb[0]), 32'(SKY));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
